// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and parameter checks
// for the inverse-cipher datapath.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } isb_state_t;

  function automatic bit lanes_ok(input int n);
    return (n == 1) || (n == 2) || (n == 4) ||
           (n == 8) || (n == 16);
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational FIPS-197 inverse S-box, one byte.
// Port names match the forward sbox.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] din,
  output logic [AES_BYTE_W-1:0] dout
);

  always_comb begin
    dout = 8'h00;
    unique case (din)
      8'h00: dout = 8'h52; 8'h01: dout = 8'h09; 8'h02: dout = 8'h6a; 8'h03: dout = 8'hd5;
      8'h04: dout = 8'h30; 8'h05: dout = 8'h36; 8'h06: dout = 8'ha5; 8'h07: dout = 8'h38;
      8'h08: dout = 8'hbf; 8'h09: dout = 8'h40; 8'h0a: dout = 8'ha3; 8'h0b: dout = 8'h9e;
      8'h0c: dout = 8'h81; 8'h0d: dout = 8'hf3; 8'h0e: dout = 8'hd7; 8'h0f: dout = 8'hfb;
      8'h10: dout = 8'h7c; 8'h11: dout = 8'he3; 8'h12: dout = 8'h39; 8'h13: dout = 8'h82;
      8'h14: dout = 8'h9b; 8'h15: dout = 8'h2f; 8'h16: dout = 8'hff; 8'h17: dout = 8'h87;
      8'h18: dout = 8'h34; 8'h19: dout = 8'h8e; 8'h1a: dout = 8'h43; 8'h1b: dout = 8'h44;
      8'h1c: dout = 8'hc4; 8'h1d: dout = 8'hde; 8'h1e: dout = 8'he9; 8'h1f: dout = 8'hcb;
      8'h20: dout = 8'h54; 8'h21: dout = 8'h7b; 8'h22: dout = 8'h94; 8'h23: dout = 8'h32;
      8'h24: dout = 8'ha6; 8'h25: dout = 8'hc2; 8'h26: dout = 8'h23; 8'h27: dout = 8'h3d;
      8'h28: dout = 8'hee; 8'h29: dout = 8'h4c; 8'h2a: dout = 8'h95; 8'h2b: dout = 8'h0b;
      8'h2c: dout = 8'h42; 8'h2d: dout = 8'hfa; 8'h2e: dout = 8'hc3; 8'h2f: dout = 8'h4e;
      8'h30: dout = 8'h08; 8'h31: dout = 8'h2e; 8'h32: dout = 8'ha1; 8'h33: dout = 8'h66;
      8'h34: dout = 8'h28; 8'h35: dout = 8'hd9; 8'h36: dout = 8'h24; 8'h37: dout = 8'hb2;
      8'h38: dout = 8'h76; 8'h39: dout = 8'h5b; 8'h3a: dout = 8'ha2; 8'h3b: dout = 8'h49;
      8'h3c: dout = 8'h6d; 8'h3d: dout = 8'h8b; 8'h3e: dout = 8'hd1; 8'h3f: dout = 8'h25;
      8'h40: dout = 8'h72; 8'h41: dout = 8'hf8; 8'h42: dout = 8'hf6; 8'h43: dout = 8'h64;
      8'h44: dout = 8'h86; 8'h45: dout = 8'h68; 8'h46: dout = 8'h98; 8'h47: dout = 8'h16;
      8'h48: dout = 8'hd4; 8'h49: dout = 8'ha4; 8'h4a: dout = 8'h5c; 8'h4b: dout = 8'hcc;
      8'h4c: dout = 8'h5d; 8'h4d: dout = 8'h65; 8'h4e: dout = 8'hb6; 8'h4f: dout = 8'h92;
      8'h50: dout = 8'h6c; 8'h51: dout = 8'h70; 8'h52: dout = 8'h48; 8'h53: dout = 8'h50;
      8'h54: dout = 8'hfd; 8'h55: dout = 8'hed; 8'h56: dout = 8'hb9; 8'h57: dout = 8'hda;
      8'h58: dout = 8'h5e; 8'h59: dout = 8'h15; 8'h5a: dout = 8'h46; 8'h5b: dout = 8'h57;
      8'h5c: dout = 8'ha7; 8'h5d: dout = 8'h8d; 8'h5e: dout = 8'h9d; 8'h5f: dout = 8'h84;
      8'h60: dout = 8'h90; 8'h61: dout = 8'hd8; 8'h62: dout = 8'hab; 8'h63: dout = 8'h00;
      8'h64: dout = 8'h8c; 8'h65: dout = 8'hbc; 8'h66: dout = 8'hd3; 8'h67: dout = 8'h0a;
      8'h68: dout = 8'hf7; 8'h69: dout = 8'he4; 8'h6a: dout = 8'h58; 8'h6b: dout = 8'h05;
      8'h6c: dout = 8'hb8; 8'h6d: dout = 8'hb3; 8'h6e: dout = 8'h45; 8'h6f: dout = 8'h06;
      8'h70: dout = 8'hd0; 8'h71: dout = 8'h2c; 8'h72: dout = 8'h1e; 8'h73: dout = 8'h8f;
      8'h74: dout = 8'hca; 8'h75: dout = 8'h3f; 8'h76: dout = 8'h0f; 8'h77: dout = 8'h02;
      8'h78: dout = 8'hc1; 8'h79: dout = 8'haf; 8'h7a: dout = 8'hbd; 8'h7b: dout = 8'h03;
      8'h7c: dout = 8'h01; 8'h7d: dout = 8'h13; 8'h7e: dout = 8'h8a; 8'h7f: dout = 8'h6b;
      8'h80: dout = 8'h3a; 8'h81: dout = 8'h91; 8'h82: dout = 8'h11; 8'h83: dout = 8'h41;
      8'h84: dout = 8'h4f; 8'h85: dout = 8'h67; 8'h86: dout = 8'hdc; 8'h87: dout = 8'hea;
      8'h88: dout = 8'h97; 8'h89: dout = 8'hf2; 8'h8a: dout = 8'hcf; 8'h8b: dout = 8'hce;
      8'h8c: dout = 8'hf0; 8'h8d: dout = 8'hb4; 8'h8e: dout = 8'he6; 8'h8f: dout = 8'h73;
      8'h90: dout = 8'h96; 8'h91: dout = 8'hac; 8'h92: dout = 8'h74; 8'h93: dout = 8'h22;
      8'h94: dout = 8'he7; 8'h95: dout = 8'had; 8'h96: dout = 8'h35; 8'h97: dout = 8'h85;
      8'h98: dout = 8'he2; 8'h99: dout = 8'hf9; 8'h9a: dout = 8'h37; 8'h9b: dout = 8'he8;
      8'h9c: dout = 8'h1c; 8'h9d: dout = 8'h75; 8'h9e: dout = 8'hdf; 8'h9f: dout = 8'h6e;
      8'ha0: dout = 8'h47; 8'ha1: dout = 8'hf1; 8'ha2: dout = 8'h1a; 8'ha3: dout = 8'h71;
      8'ha4: dout = 8'h1d; 8'ha5: dout = 8'h29; 8'ha6: dout = 8'hc5; 8'ha7: dout = 8'h89;
      8'ha8: dout = 8'h6f; 8'ha9: dout = 8'hb7; 8'haa: dout = 8'h62; 8'hab: dout = 8'h0e;
      8'hac: dout = 8'haa; 8'had: dout = 8'h18; 8'hae: dout = 8'hbe; 8'haf: dout = 8'h1b;
      8'hb0: dout = 8'hfc; 8'hb1: dout = 8'h56; 8'hb2: dout = 8'h3e; 8'hb3: dout = 8'h4b;
      8'hb4: dout = 8'hc6; 8'hb5: dout = 8'hd2; 8'hb6: dout = 8'h79; 8'hb7: dout = 8'h20;
      8'hb8: dout = 8'h9a; 8'hb9: dout = 8'hdb; 8'hba: dout = 8'hc0; 8'hbb: dout = 8'hfe;
      8'hbc: dout = 8'h78; 8'hbd: dout = 8'hcd; 8'hbe: dout = 8'h5a; 8'hbf: dout = 8'hf4;
      8'hc0: dout = 8'h1f; 8'hc1: dout = 8'hdd; 8'hc2: dout = 8'ha8; 8'hc3: dout = 8'h33;
      8'hc4: dout = 8'h88; 8'hc5: dout = 8'h07; 8'hc6: dout = 8'hc7; 8'hc7: dout = 8'h31;
      8'hc8: dout = 8'hb1; 8'hc9: dout = 8'h12; 8'hca: dout = 8'h10; 8'hcb: dout = 8'h59;
      8'hcc: dout = 8'h27; 8'hcd: dout = 8'h80; 8'hce: dout = 8'hec; 8'hcf: dout = 8'h5f;
      8'hd0: dout = 8'h60; 8'hd1: dout = 8'h51; 8'hd2: dout = 8'h7f; 8'hd3: dout = 8'ha9;
      8'hd4: dout = 8'h19; 8'hd5: dout = 8'hb5; 8'hd6: dout = 8'h4a; 8'hd7: dout = 8'h0d;
      8'hd8: dout = 8'h2d; 8'hd9: dout = 8'he5; 8'hda: dout = 8'h7a; 8'hdb: dout = 8'h9f;
      8'hdc: dout = 8'h93; 8'hdd: dout = 8'hc9; 8'hde: dout = 8'h9c; 8'hdf: dout = 8'hef;
      8'he0: dout = 8'ha0; 8'he1: dout = 8'he0; 8'he2: dout = 8'h3b; 8'he3: dout = 8'h4d;
      8'he4: dout = 8'hae; 8'he5: dout = 8'h2a; 8'he6: dout = 8'hf5; 8'he7: dout = 8'hb0;
      8'he8: dout = 8'hc8; 8'he9: dout = 8'heb; 8'hea: dout = 8'hbb; 8'heb: dout = 8'h3c;
      8'hec: dout = 8'h83; 8'hed: dout = 8'h53; 8'hee: dout = 8'h99; 8'hef: dout = 8'h61;
      8'hf0: dout = 8'h17; 8'hf1: dout = 8'h2b; 8'hf2: dout = 8'h04; 8'hf3: dout = 8'h7e;
      8'hf4: dout = 8'hba; 8'hf5: dout = 8'h77; 8'hf6: dout = 8'hd6; 8'hf7: dout = 8'h26;
      8'hf8: dout = 8'he1; 8'hf9: dout = 8'h69; 8'hfa: dout = 8'h14; 8'hfb: dout = 8'h63;
      8'hfc: dout = 8'h55; 8'hfd: dout = 8'h21; 8'hfe: dout = 8'h0c; 8'hff: dout = 8'h7d;
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// Sequential AES InvSubBytes: LANES bytes per clock,
// in place over a 128-bit state register.
module inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  localparam int G  = 16 / LANES;
  localparam int CW = (G > 1) ? $clog2(G) : 1;
  localparam logic [CW-1:0] LAST = CW'(G - 1);

  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("inv_sub_bytes: LANES=%0d is not 1/2/4/8/16", LANES);
  end

  isb_state_t state, state_nx;
  logic [CW-1:0] cnt;

  // Ascending packed ranges put group 0 / byte 0 at the MSB end.
  logic [0:G-1][0:LANES-1][AES_BYTE_W-1:0] st;
  logic [0:LANES-1][AES_BYTE_W-1:0] lane_out;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    inv_sbox u_sbox (
      .din  (st[cnt][k]),
      .dout (lane_out[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st  <= in_data;
            cnt <= '0;
          end
        end
        RUN: begin
          st[cnt] <= lane_out;
          cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign out_data  = st;

endmodule

// File: doc/inv_sub_bytes.md
# inv_sub_bytes

Sequential AES InvSubBytes engine for the decryption datapath: accepts one 128-bit state over a valid/ready handshake, applies the AES inverse S-box to all 16 bytes, and returns the result over a second valid/ready handshake. It processes LANES bytes per clock through LANES instances of a combinational inverse S-box, so the decrypt round trades latency for area. It sits between the inverse ShiftRows stage and AddRoundKey in the inverse cipher round, and mirrors the forward sbox used by the encryption path.

## Interface
- LANES, default 4: bytes substituted per clock; legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- Derived constant G = 16/LANES: the number of substitution cycles per block.
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst, input, 1: reset is synchronous and active-high.
- in_valid, input, 1: in_data holds a state to be accepted.
- in_ready, output, 1: the block can accept a state; high only in IDLE and never while rst is high.
- in_data, input, 128: input state; byte 0 is in_data[127:120] and byte 15 is in_data[7:0].
- out_valid, output, 1: out_data holds a completed result.
- out_ready, input, 1: the consumer accepts out_data.
- out_data, output, 128: the result state, in the same byte order as in_data.
- busy, output, 1: high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE. After reset the state is IDLE, group counter cnt = 0, and the state register is 0.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data into the 128-bit state register, set cnt = 0, go to RUN.
- RUN:
  - Each clock, replace bytes cnt*LANES through cnt*LANES+LANES-1 of the state register with inv_sbox(byte), working in place.
  - Increment cnt. cnt is $clog2(G) bits wide, with a minimum of 1 bit.
  - When cnt == G-1, perform the final substitution and go to DONE.
  - Processing order is byte 0 first.
- DONE:
  - out_valid = 1 and out_data = state register.
  - out_data is held stable while out_valid is high and out_ready is low.
  - On out_ready, go to IDLE.
- The block never overlaps blocks: in_ready is 0 throughout RUN and DONE, and in_data is ignored outside IDLE.
- When out_valid is 0, out_data still shows the state register, including partially substituted contents. Consumers qualify out_data with out_valid.
- Reset mid-operation (rst high in any state): return to IDLE, cnt = 0, state register = 0. The in-flight block is discarded and no out_valid pulse is produced for it.
- Inverse S-box is the full FIPS-197 InvSbox, 256 entries. Examples: 63→00, 7c→01, 16→ff, 00→52, ed→53.

## Timing
- Reset values: in_ready 0 while rst is high and 1 from the first cycle after reset is released; out_valid 0; busy 0; out_data 0.
- Latency: the input is accepted at rising edge T. out_valid is high from edge T+G, i.e. G clocks later.
  - LANES=4 gives 4 clocks.
  - LANES=1 gives 16 clocks.
  - LANES=16 gives 1 clock.
- Throughput with out_ready held high: one block per G+2 clocks. This is G RUN cycles, 1 DONE cycle, and 1 IDLE cycle before the next accept.
- Backpressure: DONE persists for any number of cycles. The output handshake completes on the edge where out_valid & out_ready are both high, and in_ready rises in the following cycle.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_W = 128 and AES_BYTE_W = 8.
  - The FSM state encoding for IDLE, RUN and DONE.
  - The legal-LANES check as a function.
- Sub-module inv_sbox: combinational, 8-bit data in, 8-bit dout, a 256-entry case table with default 8'h00. It is instantiated LANES times with a generate loop. Its port names are the same as the forward sbox so the encrypt and decrypt paths are symmetric.

## Test plan
- All-63 block: in_data = 128'h6363…63 with LANES=4 → out_data = 128'h0 with out_valid asserted exactly 4 clocks after acceptance.
- Ordered bytes: in_data = 637c777bf26b6fc53001672bfed7ab76 → out_data = 000102030405060708090a0b0c0d0e0f. Byte 0 must land in the MSB position.
- Round trip: for 200 random 128-bit values x, feed the forward S-box image of x (sbox applied bytewise) → out_data == x. Also sweep all 256 byte values through lane 0 against the InvSbox table.
- Backpressure: hold out_ready = 0 for 10 clocks in DONE.
  - out_data is stable and in_ready is 0 throughout.
  - A second in_valid is ignored.
  - After out_ready is raised, in_ready is 1 in the next cycle.
- Reset mid-RUN: assert rst at cnt = 2.
  - Next cycle: in_ready = 1, out_valid = 0, out_data = 0.
  - No result for the aborted block ever appears.
  - A following block completes correctly.
- Parameter sweep: LANES ∈ {1, 2, 8, 16} with 16'h-style vectors (00…00 → 52…52) → latency is exactly G clocks, and back-to-back blocks run at one per G+2 clocks.
